// File: rtl/kf8237_transfer_sequencer_pkg.sv
// Shared KF8237 definitions: transfer FSM state encoding and channel-index helpers
// used by the sequencer and its priority resolver.
package kf8237_transfer_sequencer_pkg;

  typedef enum logic [2:0] {
    SI = 3'd0,
    S0 = 3'd1,
    S1 = 3'd2,
    S2 = 3'd3,
    S3 = 3'd4,
    S4 = 3'd5
  } state_t;

  function automatic logic [1:0] bit2num(input logic [3:0] onehot);
    logic [1:0] num;
    case (onehot)
      4'b0010: num = 2'd1;
      4'b0100: num = 2'd2;
      4'b1000: num = 2'd3;
      default: num = 2'd0;
    endcase
    return num;
  endfunction

  function automatic logic [3:0] num2bit(input logic [1:0] num);
    return 4'b0001 << num;
  endfunction

endpackage

// File: rtl/kf8237_priority_resolver.sv
// Picks one pending DMA channel, either fixed (ch0 highest) or rotating, and keeps
// the rotation pointer naming the currently highest-priority channel.
module kf8237_priority_resolver
  import kf8237_transfer_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_master_clear,
  input  logic [3:0] i_pending,
  input  logic       i_rotating,
  input  logic       i_update,
  input  logic [1:0] i_serviced,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_index
);

  logic [1:0] r_highest;
  logic [3:0] w_fixed_grant;
  logic [3:0] w_rotating_grant;
  logic       w_found;
  logic [1:0] w_index;

  // After servicing a channel, the one following it becomes the highest priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_highest <= 2'd0;
    end else if (i_master_clear) begin
      r_highest <= 2'd0;
    end else if (i_update) begin
      r_highest <= i_serviced + 2'd1;
    end
  end

  // Isolating the lowest set bit gives the fixed-priority winner directly.
  assign w_fixed_grant = i_pending & (~i_pending + 4'd1);

  always_comb begin
    w_rotating_grant = 4'b0000;
    w_found          = 1'b0;
    w_index          = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_index = r_highest + 2'(i);
      if (!w_found && i_pending[w_index]) begin
        w_rotating_grant[w_index] = 1'b1;
        w_found                   = 1'b1;
      end
    end
  end

  assign o_grant       = i_rotating ? w_rotating_grant : w_fixed_grant;
  assign o_grant_index = bit2num(o_grant);

endmodule

// File: rtl/kf8237_transfer_sequencer.sv
// Single-transfer DMA sequencer: arbitrates DREQs, handshakes HRQ/HLDA, walks S1..S4
// and reports terminal count, EOP and autoinitialize/mask requests.
module kf8237_transfer_sequencer
  import kf8237_transfer_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_clock_posedge,
  input  logic       master_clear,
  input  logic [3:0] dma_request,
  input  logic [3:0] channel_mask,
  input  logic       rotating_priority,
  input  logic [3:0] autoinit_config,
  input  logic       hold_acknowledge,
  input  logic       underflow,
  input  logic       read_status,
  output logic       hold_request,
  output logic [3:0] dma_acknowledge,
  output logic [3:0] transfer_register_select,
  output logic       next_word,
  output logic       initialize_current_register,
  output logic       end_of_process,
  output logic [3:0] set_channel_mask,
  output logic [3:0] terminal_count
);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_channel;
  logic [3:0] w_channel_onehot;
  logic [3:0] w_pending;
  logic [3:0] w_grant;
  logic [1:0] w_grant_index;
  logic       w_normal_exit;
  logic       w_tc_event;
  logic       r_end_of_process;
  logic       r_initialize;
  logic [3:0] r_set_mask;
  logic [3:0] r_terminal_count;

  assign w_pending        = dma_request & ~channel_mask;
  assign w_channel_onehot = num2bit(r_channel);
  assign w_normal_exit    = cpu_clock_posedge && (r_state == S4) && hold_acknowledge;
  assign w_tc_event       = w_normal_exit && underflow;

  kf8237_priority_resolver u_priority_resolver (
    .clock          (clock),
    .reset          (reset),
    .i_master_clear (master_clear),
    .i_pending      (w_pending),
    .i_rotating     (rotating_priority),
    .i_update       (w_normal_exit),
    .i_serviced     (r_channel),
    .o_grant        (w_grant),
    .o_grant_index  (w_grant_index)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SI;
    end else if (master_clear) begin
      r_state <= SI;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Losing HLDA anywhere in the active cycle abandons the transfer without TC effects.
  always_comb begin
    w_next_state = r_state;
    if (cpu_clock_posedge) begin
      case (r_state)
        SI: if (|w_pending) w_next_state = S0;
        S0: begin
          if (!w_pending[r_channel]) w_next_state = SI;
          else if (hold_acknowledge) w_next_state = S1;
        end
        S1: w_next_state = hold_acknowledge ? S2 : SI;
        S2: w_next_state = hold_acknowledge ? S3 : SI;
        S3: w_next_state = hold_acknowledge ? S4 : SI;
        S4: w_next_state = SI;
        default: w_next_state = SI;
      endcase
    end
  end

  always_comb begin
    hold_request             = (r_state != SI);
    transfer_register_select = 4'b0000;
    dma_acknowledge          = 4'b0000;
    next_word                = 1'b0;
    case (r_state)
      S1: transfer_register_select = w_channel_onehot;
      S2, S3: begin
        transfer_register_select = w_channel_onehot;
        dma_acknowledge          = w_channel_onehot;
      end
      S4: begin
        transfer_register_select = w_channel_onehot;
        dma_acknowledge          = w_channel_onehot;
        next_word                = hold_acknowledge;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_channel <= 2'd0;
    end else if (master_clear) begin
      r_channel <= 2'd0;
    end else if (cpu_clock_posedge && (r_state == SI) && (|w_pending)) begin
      r_channel <= w_grant_index;
    end
  end

  // Pulses are re-evaluated every clock so they last one clock regardless of enable spacing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_end_of_process <= 1'b0;
      r_initialize     <= 1'b0;
      r_set_mask       <= 4'b0000;
      r_terminal_count <= 4'b0000;
    end else if (master_clear) begin
      r_end_of_process <= 1'b0;
      r_initialize     <= 1'b0;
      r_set_mask       <= 4'b0000;
      r_terminal_count <= 4'b0000;
    end else begin
      r_end_of_process <= w_tc_event;
      r_initialize     <= w_tc_event && autoinit_config[r_channel];
      r_set_mask       <= (w_tc_event && !autoinit_config[r_channel]) ? w_channel_onehot : 4'b0000;
      r_terminal_count <= (read_status ? 4'b0000 : r_terminal_count)
                          | (w_tc_event ? w_channel_onehot : 4'b0000);
    end
  end

  assign end_of_process              = r_end_of_process;
  assign initialize_current_register = r_initialize;
  assign set_channel_mask            = r_set_mask;
  assign terminal_count              = r_terminal_count;

endmodule
